// File: rtl/aes_pkg.sv
// Shared AES constants and helpers for the inverse cipher: S-boxes, round constants,
// FSM state encoding and the xtime-based GF(2^8) multiplier.
package aes_pkg;

  localparam int NR_AES128 = 10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_KEYEXP = 2'd1,
    ST_ROUND  = 2'd2,
    ST_DONE   = 2'd3
  } aes_state_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // Indexed directly by the key-expansion step number; entries 0 and 11..15 are never used.
  localparam logic [7:0] RCON [16] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a 4-bit constant (0x09, 0x0b, 0x0d, 0x0e) as an XOR of xtime powers.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] c);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return ({8{c[0]}} & a) ^ ({8{c[1]}} & x2) ^ ({8{c[2]}} & x4) ^ ({8{c[3]}} & x8);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then
// InvMixColumns unless is_last_i (the final round omits it).
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] s_i,
  input  logic [127:0] rk_i,
  input  logic         is_last_i,
  output logic [127:0] next_s_o
);

  logic [127:0] ak;
  logic [127:0] mc;

  // Byte n sits at row n%4, column n/4; row r is rotated right by r columns.
  for (genvar n = 0; n < 16; n++) begin : g_byte
    localparam int SRC = 4 * (((n / 4) + 4 - (n % 4)) % 4) + (n % 4);
    assign ak[127-8*n -: 8] = INV_SBOX[s_i[127-8*SRC -: 8]] ^ rk_i[127-8*n -: 8];
  end

  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] a0, a1, a2, a3;
    assign a0 = ak[127-32*c -: 8];
    assign a1 = ak[119-32*c -: 8];
    assign a2 = ak[111-32*c -: 8];
    assign a3 = ak[103-32*c -: 8];
    assign mc[127-32*c -: 32] = {
      gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9),
      gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd),
      gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb),
      gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he)
    };
  end

  assign next_s_o = is_last_i ? ak : mc;

endmodule

// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 decryptor: expands the key one round key per cycle, then one inverse round per cycle.
// Optional AES_DEC_KEY_CACHE_EN skips the expansion when the new key equals the stored schedule's key.
module aes_decrypt_iter
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy,
  output aes_state_e   dbg_state
);

  if (NR != NR_AES128) begin : g_nr_check
    $error("aes_decrypt_iter: NR must be 10 (AES-128 only)");
  end

  localparam logic [3:0] LAST_KEY    = 4'(NR);
  localparam logic [3:0] FIRST_ROUND = 4'(NR - 1);

  // Handshakes: a word moves on a rising edge where valid and ready are both high; the
  // producer keeps valid and its payload stable until that edge.

  aes_state_e   state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] s_q, s_d;
  logic [127:0] ct_q, ct_d;
  logic [127:0] out_q, out_d;
  logic [127:0] rk_q [0:NR_AES128];
  logic         rk0_we, rkn_we;
  logic         cache_hit;
  logic [127:0] rk_prev, rk_next, round_out;
  logic [31:0]  kw0, kw1, kw2, kw3, ktmp;

  // In KEYEXP cnt_q is the index of the round key being produced (1..10).
  assign rk_prev = rk_q[cnt_q - 4'd1];
  assign ktmp    = sub_word({rk_prev[23:0], rk_prev[31:24]}) ^ {RCON[cnt_q], 24'h0};
  assign kw0     = rk_prev[127:96] ^ ktmp;
  assign kw1     = rk_prev[95:64] ^ kw0;
  assign kw2     = rk_prev[63:32] ^ kw1;
  assign kw3     = rk_prev[31:0] ^ kw2;
  assign rk_next = {kw0, kw1, kw2, kw3};

  aes_inv_round u_round (
    .s_i       (s_q),
    .rk_i      (rk_q[cnt_q]),
    .is_last_i (cnt_q == 4'd0),
    .next_s_o  (round_out)
  );

`ifdef AES_DEC_KEY_CACHE_EN
  logic cache_vld_q, cache_vld_d;

  always_comb begin
    cache_vld_d = cache_vld_q;
    if (rk0_we) begin
      cache_vld_d = 1'b0;
    end else if (state_q == ST_KEYEXP && cnt_q == LAST_KEY) begin
      cache_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cache_vld_q <= 1'b0;
    else        cache_vld_q <= cache_vld_d;
  end

  assign cache_hit = cache_vld_q && (rk_q[0] == in_key);
`else
  assign cache_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    ct_d    = ct_q;
    out_d   = out_q;
    rk0_we  = 1'b0;
    rkn_we  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          ct_d = in_data;
          if (cache_hit) begin
            s_d     = in_data ^ rk_q[NR_AES128];
            cnt_d   = FIRST_ROUND;
            state_d = ST_ROUND;
          end else begin
            rk0_we  = 1'b1;
            cnt_d   = 4'd1;
            state_d = ST_KEYEXP;
          end
        end
      end
      ST_KEYEXP: begin
        rkn_we = 1'b1;
        if (cnt_q == LAST_KEY) begin
          s_d     = ct_q ^ rk_next;
          cnt_d   = FIRST_ROUND;
          state_d = ST_ROUND;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_ROUND: begin
        s_d = round_out;
        if (cnt_q == 4'd0) begin
          out_d   = round_out;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  always_ff @(posedge clk) begin
    s_q  <= s_d;
    ct_q <= ct_d;
  end

  always_ff @(posedge clk) begin
    if (rk0_we) rk_q[0] <= in_key;
    if (rkn_we) rk_q[cnt_q] <= rk_next;
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_KEYEXP) || (state_q == ST_ROUND);
  assign out_data  = out_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Self-checking bench for aes_decrypt_iter: known-answer table, backpressure, reset abort,
// back-to-back jobs and random jobs against an array-based AES reference model.
module tb_aes_decrypt_iter;
  import aes_pkg::*;

  typedef struct {
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] in_data = '0;
  logic [127:0] in_key = '0;
  logic         in_ready, out_valid, busy;
  logic [127:0] out_data;
  aes_state_e   dbg_state;

  int           checks = 0;
  int           failures = 0;
  logic [127:0] exp_q[$];
  logic [7:0]   sb [256];
  logic [7:0]   isb [256];
  logic         cache_vld = 1'b0;
  logic [127:0] cache_key = '0;

`ifdef AES_DEC_KEY_CACHE_EN
  localparam bit CACHE_ON = 1'b1;
`else
  localparam bit CACHE_ON = 1'b0;
`endif

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] TM_KEY = 128'h5468617473206d79204b756e67204675;
  localparam logic [127:0] TM_CT  = 128'h29c3505f571420f6402299b31a02d73a;
  localparam logic [127:0] TM_PT  = 128'h54776f204f6e65204e696e652054776f;

  aes_decrypt_iter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "timeout");
  end

  // Reference model: S-boxes derived from GF(2^8) inversion plus the affine map
  function automatic logic [7:0] m_gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] m_rotl8(input logic [7:0] v, input int k);
    logic [15:0] d;
    d = {v, v} << k;
    return d[15:8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (m_gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ m_rotl8(inv, 1) ^ m_rotl8(inv, 2) ^ m_rotl8(inv, 3) ^ m_rotl8(inv, 4) ^ 8'h63;
      sb[x]  = s;
      isb[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] ref_decrypt(input logic [127:0] key, input logic [127:0] ct);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   base [4];
    logic [7:0]   rc, acc;
    logic [31:0]  tmp;
    logic [127:0] res;
    base = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]} ^ {rc, 24'h0};
        rc  = m_gf_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int n = 0; n < 16; n++) s[n] = ct[127-8*n -: 8] ^ w[40 + n/4][31-8*(n%4) -: 8];
    for (int rnd = 9; rnd >= 0; rnd--) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) t[4*((c + r) % 4) + r] = isb[s[4*c + r]];
      for (int n = 0; n < 16; n++) t[n] = t[n] ^ w[4*rnd + n/4][31-8*(n%4) -: 8];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) begin
          acc = 8'h00;
          for (int k = 0; k < 4; k++) acc = acc ^ m_gf_mul(base[(k - r + 4) % 4], t[4*c + k]);
          s[4*c + r] = (rnd > 0) ? acc : t[4*c + r];
        end
    end
    for (int n = 0; n < 16; n++) res[127-8*n -: 8] = s[n];
    return res;
  endfunction

  // Expected latency from the key-cache model; a miss leaves the cache holding this key.
  function automatic int exp_lat_and_note(input logic [127:0] key);
    if (CACHE_ON && cache_vld && key == cache_key) return 10;
    cache_vld = 1'b1;
    cache_key = key;
    return 20;
  endfunction

  // Checking helpers and scoreboard
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic sb_check(input string name);
    logic [127:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s scoreboard empty actual=%0h required=<none>", name, out_data);
    end else begin
      e = exp_q.pop_front();
      check({name, " out_data"}, out_data, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(output int lat, output int ready_bad);
    lat = 0;
    ready_bad = 0;
    while (!out_valid && lat < 100) begin
      if (in_ready) ready_bad++;
      tick();
      lat++;
    end
  endtask

  // Driver: one full job, optional hold of out_ready low once the result appears
  task automatic run_job(input string name, input logic [127:0] key, input logic [127:0] ct,
                         input logic [127:0] pt, input int hold);
    int lat, ready_bad, exp_l, bad, waitc;
    logic [127:0] held;
    waitc = 0;
    while (!in_ready && waitc < 50) begin tick(); waitc++; end
    check({name, " in_ready idle"}, in_ready, 1'b1);
    exp_l = exp_lat_and_note(key);
    exp_q.push_back(pt);
    in_valid = 1'b1; in_data = ct; in_key = key;
    tick();
    in_valid = 1'b0;
    check({name, " busy after accept"}, busy, 1'b1);
    wait_out(lat, ready_bad);
    check({name, " latency"}, lat, exp_l);
    check({name, " in_ready low while busy"}, ready_bad, 0);
    bad = 0;
    held = out_data;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (out_data !== held || !out_valid || in_ready) bad++;
    end
    if (hold > 0) check({name, " held stable under backpressure"}, bad, 0);
    sb_check(name);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({name, " out_valid after retire"}, out_valid, 1'b0);
    check({name, " in_ready after retire"}, in_ready, 1'b1);
  endtask

  vec_t vecs [4];

  initial begin
    int lat, ready_bad, l1, l2, to_r5, seen;
    logic [127:0] rkeys [2];
    logic [127:0] k, c;

    build_sbox();
    vecs[0] = '{key: C1_KEY, ct: C1_CT, pt: C1_PT};
    vecs[1] = '{key: C1_KEY, ct: C1_CT, pt: C1_PT};
    vecs[2] = '{key: TM_KEY, ct: TM_CT, pt: TM_PT};
    vecs[3] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                ct:  128'h3925841d02dc09fbdc118597196a0b32,
                pt:  128'h3243f6a8885a308d313198a2e0370734};

    // Reset state
    rst_n = 1'b0;
    repeat (3) tick();
    check("reset in_ready", in_ready, 1'b1);
    check("reset out_valid", out_valid, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset out_data", out_data, '0);
    check("reset state", dbg_state, ST_IDLE);
    rst_n = 1'b1;
    tick();

    // Known-answer table (second entry repeats the C.1 key)
    for (int i = 0; i < 4; i++) run_job($sformatf("kat%0d", i), vecs[i].key, vecs[i].ct, vecs[i].pt, 0);

    // Backpressure: out_ready held low 15 cycles
    run_job("backpressure", TM_KEY, TM_CT, TM_PT, 15);

    // Reset while in ROUND with r=5
    l1 = exp_lat_and_note(C1_KEY);
    to_r5 = (l1 == 10) ? 4 : 14;
    in_valid = 1'b1; in_data = C1_CT; in_key = C1_KEY;
    tick();
    in_valid = 1'b0;
    repeat (to_r5) tick();
    check("abort pre-reset state", dbg_state, ST_ROUND);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    cache_vld = 1'b0;
    check("abort state", dbg_state, ST_IDLE);
    check("abort out_valid", out_valid, 1'b0);
    check("abort out_data", out_data, '0);
    check("abort in_ready", in_ready, 1'b1);
    check("abort busy", busy, 1'b0);
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (out_valid) seen++;
    end
    check("abort no output", seen, 0);
    run_job("post-reset c1", C1_KEY, C1_CT, C1_PT, 0);

    // Back-to-back with in_valid held high
    l1 = exp_lat_and_note(C1_KEY);
    exp_q.push_back(C1_PT);
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = C1_CT; in_key = C1_KEY;
    tick();
    in_data = TM_CT; in_key = TM_KEY;
    wait_out(lat, ready_bad);
    check("b2b first latency", lat, l1);
    check("b2b first in_ready low", ready_bad, 0);
    sb_check("b2b first");
    tick();
    check("b2b retire out_valid", out_valid, 1'b0);
    check("b2b retire in_ready", in_ready, 1'b1);
    l2 = exp_lat_and_note(TM_KEY);
    exp_q.push_back(TM_PT);
    tick();
    in_valid = 1'b0;
    check("b2b second accepted", busy, 1'b1);
    wait_out(lat, ready_bad);
    check("b2b second latency", lat, l2);
    sb_check("b2b second");
    tick();
    out_ready = 1'b0;
    check("b2b final in_ready", in_ready, 1'b1);

    // Random jobs against the reference model, keys drawn from a small pool
    rkeys[0] = {$urandom(), $urandom(), $urandom(), $urandom()};
    rkeys[1] = {$urandom(), $urandom(), $urandom(), $urandom()};
    for (int i = 0; i < 8; i++) begin
      k = rkeys[$urandom_range(0, 1)];
      c = {$urandom(), $urandom(), $urandom(), $urandom()};
      run_job($sformatf("rand%0d", i), k, c, ref_decrypt(k, c), $urandom_range(0, 3));
    end

    check("scoreboard drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
